// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings shared by the ALU core, wrapper and bench
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath; carry/overflow exist only with ALU_FLAGS_EN
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
`ifdef ALU_FLAGS_EN
    output logic             carry,
    output logic             overflow,
`endif
    output logic [WIDTH-1:0] result
);

    // One extra bit on the arithmetic/shift paths holds carry, borrow or the last bit shifted out.
`ifdef ALU_FLAGS_EN
    localparam int XW = WIDTH + 1;
`else
    localparam int XW = WIDTH;
`endif

    alu_op_e       op_e;
    logic [XW-1:0] sum;
    logic [XW-1:0] diff;
    logic [XW-1:0] shl;

    assign op_e = alu_op_e'(op);
    assign sum  = XW'(a) + XW'(b);
    assign diff = XW'(a) - XW'(b);
    assign shl  = XW'(a) << b[1:0];

    always_comb begin
        result = '0;
        case (op_e)
            OP_ADD: result = sum[WIDTH-1:0];
            OP_SUB: result = diff[WIDTH-1:0];
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: result = shl[WIDTH-1:0];
            OP_SHR: result = a >> b[1:0];
        endcase
    end

`ifdef ALU_FLAGS_EN
    always_comb begin
        carry    = 1'b0;
        overflow = 1'b0;
        case (op_e)
            OP_ADD: begin
                carry    = sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                carry    = diff[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHL:  carry = shl[WIDTH];
            default: ;
        endcase
    end
`endif

endmodule

// File: rtl/alu_model.sv
// rtl/alu_model.sv - registered ALU wrapper; flag outputs exist only with ALU_FLAGS_EN
module alu_model #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] opperand_1,
    input  logic [WIDTH-1:0] opperand_2,
    input  logic [2:0]       opcode,
`ifdef ALU_FLAGS_EN
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_v,
`endif
    output logic [WIDTH-1:0] alu_out
);

    logic [WIDTH-1:0] result;
`ifdef ALU_FLAGS_EN
    logic carry;
    logic overflow;
`endif

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a        (opperand_1),
        .b        (opperand_2),
        .op       (opcode),
`ifdef ALU_FLAGS_EN
        .carry    (carry),
        .overflow (overflow),
`endif
        .result   (result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out <= '0;
        end else begin
            alu_out <= result;
        end
    end

`ifdef ALU_FLAGS_EN
    // Zero flag tracks the value being registered, so it always agrees with alu_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_c <= 1'b0;
            flag_z <= 1'b1;
            flag_v <= 1'b0;
        end else begin
            flag_c <= carry;
            flag_z <= (result == '0);
            flag_v <= overflow;
        end
    end
`endif

endmodule

// File: tb/tb_alu_model.sv
// tb/tb_alu_model.sv - table-driven scoreboard bench for alu_model; flag checks with ALU_FLAGS_EN
module tb_alu_model;
    import alu_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] opperand_1 = '0;
    logic [W-1:0] opperand_2 = '0;
    logic [2:0]   opcode = 3'b000;
    logic [W-1:0] alu_out;
`ifdef ALU_FLAGS_EN
    logic         flag_c;
    logic         flag_z;
    logic         flag_v;
`endif

    alu_model #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .opperand_1 (opperand_1),
        .opperand_2 (opperand_2),
        .opcode     (opcode),
`ifdef ALU_FLAGS_EN
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .flag_v     (flag_v),
`endif
        .alu_out    (alu_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         rst;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic         c;
        logic         z;
        logic         v;
    } vec_t;

    vec_t sbq[$];
    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;

    function automatic vec_t mk(input string name, input logic r, input logic [2:0] op,
                                input int a, input int b, input int y,
                                input logic c, input logic z, input logic v);
        vec_t t;
        t.name = name; t.rst = r; t.op = op;
        t.a = W'(a); t.b = W'(b); t.y = W'(y);
        t.c = c; t.z = z; t.v = v;
        return t;
    endfunction

    // Integer reference model for random vectors.
    function automatic vec_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t t;
        int ia = int'(a);
        int ib = int'(b);
        int sa = (ia >= 8) ? ia - 16 : ia;
        int sb = (ib >= 8) ? ib - 16 : ib;
        int sh = int'(b[1:0]);
        int res = 0;
        int sres = 0;
        t.name = "rand"; t.rst = 1'b0; t.op = op; t.a = a; t.b = b;
        t.c = 1'b0; t.v = 1'b0;
        case (op)
            3'd0: begin res = ia + ib; t.c = (res > 15); sres = sa + sb; t.v = (sres > 7) || (sres < -8); end
            3'd1: begin res = ia - ib; t.c = (ia < ib); sres = sa - sb; t.v = (sres > 7) || (sres < -8); end
            3'd2: res = int'(a & b);
            3'd3: res = int'(a | b);
            3'd4: res = int'(a ^ b);
            3'd5: res = 15 - ia;
            3'd6: begin res = ia * (1 << sh); t.c = (sh > 0) && (((ia >> (4 - sh)) & 1) == 1); end
            default: res = ia >> sh;
        endcase
        t.y = W'(res & 15);
        t.z = (t.y == '0);
        return t;
    endfunction

    task automatic check(input vec_t e);
        checks++;
        if (alu_out !== e.y) begin
            failures++;
            $display("FAIL %s alu_out got %0d expected %0d (op=%0d a=%0d b=%0d)",
                     e.name, alu_out, e.y, e.op, e.a, e.b);
        end
`ifdef ALU_FLAGS_EN
        checks++;
        if ({flag_c, flag_z, flag_v} !== {e.c, e.z, e.v}) begin
            failures++;
            $display("FAIL %s flags czv got %b%b%b expected %b%b%b",
                     e.name, flag_c, flag_z, flag_v, e.c, e.z, e.v);
        end
`endif
    endtask

    task automatic step(input vec_t r);
        @(negedge clk);
        if (sbq.size() != 0) check(sbq.pop_front());
        rst        = r.rst;
        opcode     = r.op;
        opperand_1 = r.a;
        opperand_2 = r.b;
        sbq.push_back(r);
    endtask

    initial begin
        tbl.push_back(mk("reset",     1, OP_ADD, 3, 1, 0, 0, 1, 0));
        tbl.push_back(mk("add_3_1",   0, OP_ADD, 3, 1, 4, 0, 0, 0));
        tbl.push_back(mk("sub_3_1",   0, OP_SUB, 3, 1, 2, 0, 0, 0));
        tbl.push_back(mk("and_3_1",   0, OP_AND, 3, 1, 1, 0, 0, 0));
        tbl.push_back(mk("or_3_1",    0, OP_OR,  3, 1, 3, 0, 0, 0));
        tbl.push_back(mk("add_wrap",  0, OP_ADD, 15, 1, 0, 1, 1, 0));
        tbl.push_back(mk("sub_wrap",  0, OP_SUB, 0, 1, 15, 1, 0, 0));
        tbl.push_back(mk("add_ovf",   0, OP_ADD, 7, 1, 8, 0, 0, 1));
        tbl.push_back(mk("xor_5_3",   0, OP_XOR, 5, 3, 6, 0, 0, 0));
        tbl.push_back(mk("not_5",     0, OP_NOT, 5, 9, 10, 0, 0, 0));
        tbl.push_back(mk("shl_9_1",   0, OP_SHL, 9, 1, 2, 1, 0, 0));
        tbl.push_back(mk("shr_8_3",   0, OP_SHR, 8, 3, 1, 0, 0, 0));
        tbl.push_back(mk("sub_ovf",   0, OP_SUB, 8, 1, 7, 0, 0, 1));
        tbl.push_back(mk("shl_by0",   0, OP_SHL, 9, 4, 9, 0, 0, 0));
        tbl.push_back(mk("shl_3_3",   0, OP_SHL, 3, 3, 8, 1, 0, 0));
        tbl.push_back(mk("shr_zero",  0, OP_SHR, 1, 1, 0, 0, 1, 0));
        tbl.push_back(mk("hold_pre",  0, OP_ADD, 2, 2, 4, 0, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

        // Output must not follow operand changes made between edges.
        @(negedge clk);
        check(sbq.pop_front());
        opperand_1 = 4'd7;
        sbq.push_back(mk("hold_post", 0, OP_ADD, 7, 2, 9, 0, 0, 1));
        #1;
        checks++;
        if (alu_out !== 4'd4) begin
            failures++;
            $display("FAIL hold alu_out got %0d expected 4", alu_out);
        end

        // Reset mid-stream wins over the computed result; result returns one edge after release.
        step(mk("busy",      0, OP_ADD, 5, 5, 10, 0, 0, 1));
        step(mk("mid_rst",   1, OP_ADD, 3, 1, 0, 0, 1, 0));
        step(mk("after_rst", 0, OP_ADD, 3, 1, 4, 0, 0, 0));

        for (int i = 0; i < 48; i++) begin
            logic [2:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = 3'($urandom_range(0, 7));
            a  = W'($urandom_range(0, 15));
            b  = W'($urandom_range(0, 15));
            step(model(op, a, b));
        end

        @(negedge clk);
        if (sbq.size() != 0) check(sbq.pop_front());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
